// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the LSU-side data memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

  localparam logic [3:0] DMEM_BE_ALL = 4'b1111;

  // Wait counter only has to hold LATENCY-1, but never collapses below one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 0) ? $clog2(latency + 1) : 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Word-organised storage with per-byte-lane write enables and a registered read port.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clock,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // No reset: contents and the read register survive reset on purpose.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side end of the LSU data interface: grant, fixed wait, one-cycle response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_addr_valid_ip,
  input  logic [31:0] data_addr_ip,
  input  logic        data_we_ip,
  input  logic [3:0]  data_be_ip,
  input  logic [31:0] data_wdata_ip,
  output logic        data_gnt_op,
  output logic        data_rvalid_op,
  output logic [31:0] mem_data_op,
  output logic        data_err_op
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  dmem_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q;
  logic          err_q;
  logic          rd_ok_q;

  logic [31:0]   req_addr_q;
  logic [31:0]   req_wdata_q;
  logic          req_we_q;
  logic [3:0]    req_be_q;

  logic          accept;
  logic          commit;
  logic [31:0]   cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          cmd_we;
  logic [3:0]    cmd_be;
  logic [29:0]   cmd_word;
  logic          cmd_err;
  logic [3:0]    arr_we;
  logic          arr_re;
  logic [31:0]   arr_rdata;
  logic          unused_addr_lsbs;

  assign accept = gnt_q & data_addr_valid_ip;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (accept) begin
          if (LATENCY > 0) begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = DMEM_RESP;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) state_d = DMEM_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // With zero latency the commit edge is the acceptance edge, so the live
  // inputs are used before they have landed in the request registers.
  assign cmd_addr  = (state_q == DMEM_IDLE) ? data_addr_ip  : req_addr_q;
  assign cmd_wdata = (state_q == DMEM_IDLE) ? data_wdata_ip : req_wdata_q;
  assign cmd_we    = (state_q == DMEM_IDLE) ? data_we_ip    : req_we_q;
  assign cmd_be    = (state_q == DMEM_IDLE) ? data_be_ip    : req_be_q;
  assign cmd_word  = cmd_addr[31:2];
  assign unused_addr_lsbs = ^cmd_addr[1:0];

  assign cmd_err = ($unsigned(32'(cmd_word)) >= $unsigned(32'(DEPTH_WORDS))) |
                   (cmd_we & (cmd_be == 4'b0000));

  assign commit = (state_d == DMEM_RESP);
  assign arr_we = {4{commit & cmd_we & ~cmd_err}} & cmd_be;
  assign arr_re = commit & ~cmd_we & ~cmd_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= (state_d == DMEM_IDLE);
      if (commit) begin
        err_q <= cmd_err;
        if (!cmd_we) rd_ok_q <= ~cmd_err;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      req_addr_q  <= data_addr_ip;
      req_wdata_q <= data_wdata_ip;
      req_we_q    <= data_we_ip;
      req_be_q    <= data_be_ip;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (cmd_word[AW-1:0]),
    .wdata (cmd_wdata),
    .rdata (arr_rdata)
  );

  // The read register has no reset; rd_ok_q supplies the zero after reset or an errored read.
  assign mem_data_op    = rd_ok_q ? arr_rdata : 32'h0;
  assign data_gnt_op    = gnt_q;
  assign data_rvalid_op = (state_q == DMEM_RESP);
  assign data_err_op    = err_q & (state_q == DMEM_RESP);

endmodule
